stream_rr_arb: RTL and testbench
================================

# stream_rr_arb

Round-robin arbiter sharing one valid/ready stream among N_REQ requesters, with packet locking on a `last` flag. The output is a forward-registered stage, one cycle of latency, full throughput. It sits in front of a shared downstream register slice or pipeline so that several producers can drive it without payload interleaving inside a packet.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters; legal values are ≥ 2, and non-powers of two are allowed.
- `PLD_WIDTH`, default 32: payload width per beat.
- `SEL_W`, default `$clog2(N_REQ)`: width of the grant index. Derived; do not override.

**Ports**
- `clk`  in  1: the single clock; everything is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_vld`  in  N_REQ: per-requester valid.
- `s_rdy`  out  N_REQ: per-requester ready.
- `s_pld`  in  N_REQ*PLD_WIDTH: requester i occupies bits `[i*PLD_WIDTH +: PLD_WIDTH]`.
- `s_last`  in  N_REQ: per-requester end-of-packet flag.
- `m_vld`  out  1: output valid (registered).
- `m_rdy`  in  1: downstream ready.
- `m_pld`  out  PLD_WIDTH: output payload (registered).
- `m_last`  out  1: output end-of-packet (registered).
- `m_sel`  out  SEL_W: index of the requester that produced the current output beat (registered).

## Operation

**Output free**
- `out_free = !m_vld || m_rdy`.

**Arbitration state**
- State `IDLE`/`LOCK`, plus `lock_id` (SEL_W) and `rr_ptr` (SEL_W).

**Grant, combinational**
- In `LOCK`: `g = lock_id`.
- In `IDLE`: `g` is the first i with `s_vld[i]=1`, scanning `rr_ptr, rr_ptr+1, …, N_REQ-1, 0, …, rr_ptr-1`.
- If no request is present, there is no grant.

**Ready and accept**
- `s_rdy[i] = out_free && grant valid && (i == g)`. All other `s_rdy` bits are 0.
- Accept = `s_vld[g] && s_rdy[g]`.

**On accept**
- Load `m_pld`, `m_last` and `m_sel` from requester g, and set `m_vld=1`.
- If `s_last[g]=0`: move to `LOCK` with `lock_id=g`.
- If `s_last[g]=1`: move to `IDLE` and set `rr_ptr = (g==N_REQ-1) ? 0 : g+1`.

**No accept**
- If `m_rdy=1`, clear `m_vld`.
- Otherwise hold all output registers.

**LOCK behaviour**
- While in `LOCK`, a deasserted `s_vld[lock_id]` produces bubbles.
- No other requester is granted until the last beat of the locked packet is accepted.

**Reset values (async)**
- `m_vld=0`, `m_pld=0`, `m_last=0`, `m_sel=0`.
- State `IDLE`, `rr_ptr=0`, `lock_id=0`.
- `s_rdy` resets to 0 because it follows from `IDLE` with no requests.

**Reset mid-packet**
- Asserting reset mid-packet drops the lock and the output beat immediately. No recovery is attempted.

**Payload hold**
- `m_pld`, `m_last` and `m_sel` are stable while `m_vld && !m_rdy`.

## Timing

- Latency: a beat accepted at edge k is visible on `m_*` after edge k and transfers at the first edge where `m_rdy=1`.
- Throughput is 1 beat/cycle: accept and drain in the same cycle are allowed, because `out_free` includes `m_rdy`.
- There is a combinational path from `m_rdy` and `s_vld` to `s_rdy`. Upstream must not make `s_vld` depend on `s_rdy`.
- The grant takes effect in the same cycle as the request. There are no idle cycles between packets from different requesters.
- `rr_ptr` and state update only on accept edges. A requester dropping `s_vld` before it is accepted loses nothing.

## Configuration

- `STREAM_RR_ARB_LOCK_EN` defined: packet locking as described above.
- `STREAM_RR_ARB_LOCK_EN` undefined:
  - The state stays `IDLE` permanently and every beat is arbitrated independently.
  - `rr_ptr` advances to g+1 on every accept.
  - `s_last` is still registered onto `m_last` but does not affect arbitration.

## Test plan

- **Reset and round-robin:** after reset, all four requesters hold `s_vld=1`, `s_last=1`, and `m_rdy=1` is constant. Required response: `m_sel` sequence 0,1,2,3,0,… with one beat per cycle; `m_pld` matches the per-requester payload.
- **Packet lock (macro defined):** requester 2 sends a 3-beat packet (last on beat 3) while requester 0 requests continuously. Required response: `m_sel` = 2,2,2 and then 0; `s_rdy[0]=0` throughout the lock, including during an injected `s_vld[2]` bubble cycle.
- **Backpressure:** hold `m_rdy=0` for 5 cycles with an output beat pending. Required response: all `s_rdy=0`; `m_pld`, `m_last` and `m_sel` are stable; on `m_rdy=1`, a new beat is accepted in the same cycle.
- **Wrap with N_REQ=3:** `rr_ptr=2`, requesters 0 and 2 active. Required response: grant to 2, then to 0; the pointer wraps 2→0 and never reaches 3.
- **Mid-packet reset:** assert `rst_n=0` while in `LOCK` on requester 1. Required response: `m_vld=0` immediately; after release, requester 3 alone is granted first (state `IDLE`, `rr_ptr=0`, scan 0→3).
- **Macro undefined:** requesters 1 and 2 both send `s_last=0` beats. Required response: `m_sel` alternates 1,2,1,2; `m_last` follows the inputs.

Source files
------------

// File: rtl/stream_rr_arb_if.sv
// rtl/stream_rr_arb_if.sv - valid/ready bundle joining N_REQ requesters, the round-robin arbiter and its downstream
// The arbiter connects through the slave modport; the environment that drives requests and m_rdy uses master.
interface stream_rr_arb_if #(
  parameter int N_REQ     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int SEL_W     = $clog2(N_REQ)
) ();

  logic [N_REQ-1:0]           s_vld;
  logic [N_REQ-1:0]           s_rdy;
  logic [N_REQ*PLD_WIDTH-1:0] s_pld;
  logic [N_REQ-1:0]           s_last;
  logic                       m_vld;
  logic                       m_rdy;
  logic [PLD_WIDTH-1:0]       m_pld;
  logic                       m_last;
  logic [SEL_W-1:0]           m_sel;

  modport slave (
    input  s_vld, s_pld, s_last, m_rdy,
    output s_rdy, m_vld, m_pld, m_last, m_sel
  );

  modport master (
    output s_vld, s_pld, s_last, m_rdy,
    input  s_rdy, m_vld, m_pld, m_last, m_sel
  );

endinterface

// File: rtl/stream_rr_arb.sv
// rtl/stream_rr_arb.sv - round-robin stream arbiter with a forward-registered output stage
// Define STREAM_RR_ARB_LOCK_EN to hold the grant on one requester until its last beat is accepted.
module stream_rr_arb #(
  parameter int N_REQ     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int SEL_W     = $clog2(N_REQ)
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_rr_arb_if.slave bus
);

  logic [SEL_W-1:0]     rr_ptr;
  logic [SEL_W-1:0]     rr_ptr_nxt;
  logic [N_REQ-1:0]     vld_rot;
  logic                 rot_hit;
  logic [SEL_W-1:0]     rot_ofs;
  logic [SEL_W:0]       scan_sum;
  logic [SEL_W-1:0]     scan_idx;
  logic                 grant_vld;
  logic [SEL_W-1:0]     grant_idx;
  logic [SEL_W-1:0]     grant_succ;
  logic [PLD_WIDTH-1:0] grant_pld;
  logic                 grant_last;
  logic                 out_free;
  logic                 accept;

  logic                 m_vld_q;
  logic                 m_last_q;
  logic [PLD_WIDTH-1:0] m_pld_q;
  logic [SEL_W-1:0]     m_sel_q;

`ifdef STREAM_RR_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] lock_id;
  logic [SEL_W-1:0] lock_id_nxt;
  logic             lock_vld;
`endif

  assign out_free = !m_vld_q || bus.m_rdy;

  // Rotate requests so that bit 0 is rr_ptr; the first set bit is the scan offset.
  assign vld_rot = N_REQ'({bus.s_vld, bus.s_vld} >> rr_ptr);

  always_comb begin
    rot_hit = 1'b0;
    rot_ofs = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!rot_hit && vld_rot[k]) begin
        rot_hit = 1'b1;
        rot_ofs = SEL_W'(k);
      end
    end
  end

  assign scan_sum = {1'b0, rr_ptr} + {1'b0, rot_ofs};
  assign scan_idx = (scan_sum >= (SEL_W+1)'(N_REQ)) ? SEL_W'(scan_sum - (SEL_W+1)'(N_REQ))
                                                    : scan_sum[SEL_W-1:0];

`ifdef STREAM_RR_ARB_LOCK_EN
  always_comb begin
    lock_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (lock_id == SEL_W'(i)) begin
        lock_vld = bus.s_vld[i];
      end
    end
  end

  assign grant_idx = (state == LOCK) ? lock_id  : scan_idx;
  assign grant_vld = (state == LOCK) ? lock_vld : rot_hit;
`else
  assign grant_idx = scan_idx;
  assign grant_vld = rot_hit;
`endif

  assign accept     = grant_vld && out_free;
  assign grant_succ = (grant_idx == SEL_W'(N_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_comb begin
    grant_pld  = '0;
    grant_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_pld  = bus.s_pld[i*PLD_WIDTH +: PLD_WIDTH];
        grant_last = bus.s_last[i];
      end
    end
  end

  always_comb begin
    bus.s_rdy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.s_rdy[i] = out_free && grant_vld && (grant_idx == SEL_W'(i));
    end
  end

`ifdef STREAM_RR_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_id <= '0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  // A non-last beat pins the grant; the pointer only moves once the packet closes.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    rr_ptr_nxt  = rr_ptr;
    if (accept) begin
      if (!grant_last) begin
        state_nxt   = LOCK;
        lock_id_nxt = grant_idx;
      end else begin
        state_nxt  = IDLE;
        rr_ptr_nxt = grant_succ;
      end
    end
  end
`else
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (accept) begin
      rr_ptr_nxt = grant_succ;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld_q  <= 1'b0;
      m_pld_q  <= '0;
      m_last_q <= 1'b0;
      m_sel_q  <= '0;
    end else if (accept) begin
      m_vld_q  <= 1'b1;
      m_pld_q  <= grant_pld;
      m_last_q <= grant_last;
      m_sel_q  <= grant_idx;
    end else if (bus.m_rdy) begin
      m_vld_q  <= 1'b0;
    end
  end

  assign bus.m_vld  = m_vld_q;
  assign bus.m_pld  = m_pld_q;
  assign bus.m_last = m_last_q;
  assign bus.m_sel  = m_sel_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// tb/tb_stream_rr_arb.sv - bench for stream_rr_arb (N_REQ=4 and N_REQ=3 instances) against a queue-free arbitration model
// Honours STREAM_RR_ARB_LOCK_EN in both the model and the directed packet-lock scenario.
module tb_stream_rr_arb;

`ifdef STREAM_RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_rr_arb_if #(.N_REQ(4), .PLD_WIDTH(32)) bus4 ();
  stream_rr_arb_if #(.N_REQ(3), .PLD_WIDTH(32)) bus3 ();

  stream_rr_arb #(.N_REQ(4), .PLD_WIDTH(32)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  stream_rr_arb #(.N_REQ(3), .PLD_WIDTH(32)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          ptr;
    bit          locked;
    int          lid;
    bit          vld;
    logic [31:0] pld;
    bit          last;
    int          sel;
  } mdl_t;

  mdl_t md [2];

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.ptr = 0; m.locked = 0; m.lid = 0;
    m.vld = 0; m.pld = '0; m.last = 0; m.sel = 0;
    return m;
  endfunction

  // Winner is the locked owner (if requesting) or the first requester at or after ptr, circularly.
  function automatic int mdl_grant(input mdl_t m, input int n, input logic [3:0] vld);
    if (m.locked) return vld[m.lid] ? m.lid : -1;
    for (int k = 0; k < n; k++) begin
      if (vld[(m.ptr + k) % n]) return (m.ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic step(input int k, input int n, input logic [3:0] vld, input logic [3:0] lst,
                      input logic [127:0] pld, input logic mrdy, input logic [3:0] rdy,
                      input logic mv, input logic [31:0] mp, input logic ml, input int ms);
    mdl_t m;
    int g;
    logic [3:0] erdy;
    string p;
    p = (k == 0) ? "n4" : "n3";
    if (!rst_n) md[k] = mdl_rst();
    m = md[k];
    g = mdl_grant(m, n, vld);
    erdy = 4'b0;
    if (g >= 0 && (!m.vld || mrdy)) erdy = 4'(1 << g);
    chk({p, "_s_rdy"},  64'(rdy), 64'(erdy));
    chk({p, "_m_vld"},  64'(mv),  64'(m.vld));
    chk({p, "_m_pld"},  64'(mp),  64'(m.pld));
    chk({p, "_m_last"}, 64'(ml),  64'(m.last));
    chk({p, "_m_sel"},  64'(ms),  64'(m.sel));
    if (!rst_n) return;
    if (erdy != 4'b0) begin
      m.vld  = 1'b1;
      m.pld  = pld[g*32 +: 32];
      m.last = lst[g];
      m.sel  = g;
      if (LOCK_EN && !lst[g]) begin
        m.locked = 1'b1;
        m.lid    = g;
      end else begin
        m.locked = 1'b0;
        m.ptr    = (g + 1) % n;
      end
    end else if (mrdy) begin
      m.vld = 1'b0;
    end
    md[k] = m;
  endtask

  always @(negedge clk) begin
    step(0, 4, bus4.s_vld, bus4.s_last, bus4.s_pld, bus4.m_rdy, bus4.s_rdy,
         bus4.m_vld, bus4.m_pld, bus4.m_last, int'(bus4.m_sel));
    step(1, 3, {1'b0, bus3.s_vld}, {1'b0, bus3.s_last}, {32'b0, bus3.s_pld}, bus3.m_rdy,
         {1'b0, bus3.s_rdy}, bus3.m_vld, bus3.m_pld, bus3.m_last, int'(bus3.m_sel));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic r);
    bus4.s_vld  = v;
    bus4.s_last = l;
    bus4.m_rdy  = r;
  endtask

  task automatic set_pld4(input int i, input logic [31:0] v);
    bus4.s_pld[i*32 +: 32] = v;
  endtask

  logic [1:0]  sel_hold;
  logic [31:0] pld_hold;

  initial begin
    rst_n = 1'b1;
    drive4(4'b0, 4'b0, 1'b0);
    bus4.s_pld  = '0;
    bus3.s_vld  = '0;
    bus3.s_last = '0;
    bus3.s_pld  = '0;
    bus3.m_rdy  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_m_vld",  64'(bus4.m_vld),  64'd0);
    chk("rst_m_pld",  64'(bus4.m_pld),  64'd0);
    chk("rst_m_last", 64'(bus4.m_last), 64'd0);
    chk("rst_m_sel",  64'(bus4.m_sel),  64'd0);
    chk("rst_s_rdy",  64'(bus4.s_rdy),  64'd0);
    chk("rst_n3_vld", 64'(bus3.m_vld),  64'd0);
    repeat (2) cyc();

    // Round robin with every requester presenting single-beat packets.
    for (int i = 0; i < 4; i++) set_pld4(i, 32'hC0DE_0000 + 32'(i));
    drive4(4'b1111, 4'b1111, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_sel", 64'(bus4.m_sel), 64'(i % 4));
      chk("rr_pld", 64'(bus4.m_pld), 64'(32'hC0DE_0000 + 32'(i % 4)));
    end

    // Backpressure with a beat pending.
    bus4.m_rdy = 1'b0;
    sel_hold = bus4.m_sel;
    pld_hold = bus4.m_pld;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_s_rdy", 64'(bus4.s_rdy), 64'd0);
      cyc();
      chk("bp_sel_hold", 64'(bus4.m_sel), 64'(sel_hold));
      chk("bp_pld_hold", 64'(bus4.m_pld), 64'(pld_hold));
      chk("bp_vld_hold", 64'(bus4.m_vld), 64'd1);
    end
    bus4.m_rdy = 1'b1;
    #1 chk("bp_resume_rdy", 64'(bus4.s_rdy), 64'b0001);
    cyc();
    chk("bp_resume_sel", 64'(bus4.m_sel), 64'd0);
    drive4(4'b0, 4'b0, 1'b1);
    cyc();

`ifdef STREAM_RR_ARB_LOCK_EN
    set_pld4(2, 32'hB1);
    drive4(4'b0100, 4'b0000, 1'b1);
    #1 chk("lk_rdy1", 64'(bus4.s_rdy), 64'b0100);
    cyc();
    chk("lk_sel1", 64'(bus4.m_sel), 64'd2);
    set_pld4(2, 32'hB2);
    drive4(4'b0101, 4'b0000, 1'b1);
    #1 chk("lk_rdy2", 64'(bus4.s_rdy), 64'b0100);
    cyc();
    chk("lk_sel2", 64'(bus4.m_sel), 64'd2);
    chk("lk_pld2", 64'(bus4.m_pld), 64'hB2);
    drive4(4'b0001, 4'b0000, 1'b1);
    #1 chk("lk_bubble_rdy", 64'(bus4.s_rdy), 64'b0000);
    cyc();
    chk("lk_bubble_vld", 64'(bus4.m_vld), 64'd0);
    set_pld4(2, 32'hB3);
    drive4(4'b0101, 4'b0100, 1'b1);
    #1 chk("lk_rdy3", 64'(bus4.s_rdy), 64'b0100);
    cyc();
    chk("lk_sel3", 64'(bus4.m_sel), 64'd2);
    chk("lk_last3", 64'(bus4.m_last), 64'd1);
    drive4(4'b0001, 4'b0001, 1'b1);
    #1 chk("lk_after_rdy", 64'(bus4.s_rdy), 64'b0001);
    cyc();
    chk("lk_after_sel", 64'(bus4.m_sel), 64'd0);
`else
    drive4(4'b0001, 4'b1111, 1'b1);
    cyc();
    drive4(4'b0110, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("nl_sel", 64'(bus4.m_sel), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("nl_last", 64'(bus4.m_last), 64'd0);
    end
`endif
    drive4(4'b0, 4'b0, 1'b1);
    cyc();

    // Pointer wrap on the three-requester instance.
    bus3.s_pld  = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    bus3.s_last = 3'b111;
    bus3.m_rdy  = 1'b1;
    bus3.s_vld  = 3'b010;
    cyc();
    bus3.s_vld  = 3'b101;
    #1 chk("wrap_rdy_a", 64'(bus3.s_rdy), 64'b100);
    cyc();
    chk("wrap_sel_a", 64'(bus3.m_sel), 64'd2);
    #1 chk("wrap_rdy_b", 64'(bus3.s_rdy), 64'b001);
    cyc();
    chk("wrap_sel_b", 64'(bus3.m_sel), 64'd0);
    chk("wrap_pld_b", 64'(bus3.m_pld), 64'h3333_0000);
    bus3.s_vld = 3'b000;
    cyc();

    // Reset asserted mid-packet on requester 1.
    drive4(4'b0010, 4'b0000, 1'b1);
    cyc();
    drive4(4'b0000, 4'b0000, 1'b0);
    cyc();
    chk("mr_pending_vld", 64'(bus4.m_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_vld_drop", 64'(bus4.m_vld), 64'd0);
    chk("mr_sel_drop", 64'(bus4.m_sel), 64'd0);
    drive4(4'b1000, 4'b1000, 1'b1);
    cyc();
    rst_n = 1'b1;
    #1 chk("mr_rdy3", 64'(bus4.s_rdy), 64'b1000);
    cyc();
    chk("mr_sel3", 64'(bus4.m_sel), 64'd3);

    // Random traffic on both instances, checked by the per-cycle model.
    for (int c = 0; c < 600; c++) begin
      bus4.s_vld = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        bus4.s_last[i] = ($urandom_range(0, 2) == 0);
        set_pld4(i, $urandom);
      end
      bus4.m_rdy  = ($urandom_range(0, 3) != 0);
      bus3.s_vld  = 3'($urandom);
      bus3.s_last = 3'($urandom);
      bus3.s_pld  = {$urandom, $urandom, $urandom};
      bus3.m_rdy  = ($urandom_range(0, 2) != 0);
      cyc();
    end

    drive4(4'b0, 4'b0, 1'b1);
    bus3.s_vld = 3'b000;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
